// File: rtl/adpll_lock_sequencer.sv
// ADPLL reset/acquire/lock supervisor; error_i is sampled once per synchronized ref_clk_i rising edge.
// All outputs registered: one cycle after the deciding edge. There is no backpressure; samples are consumed as they arrive.
module adpll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TOL     = 2,
  parameter int UNLOCK_TOL   = 8,
  parameter int LOCK_COUNT   = 64,
  parameter int UNLOCK_COUNT = 4,
  parameter int ACQ_TIMEOUT  = 1024,
  parameter int MAX_RETRY    = 3
) (
  input  logic       fpga_clk_i,
  input  logic       rst_pbn_i,
  input  logic       ref_clk_i,
  input  logic [7:0] error_i,
  input  logic       start_i,
  input  logic [1:0] ref_sel_req_i,
  output logic       adpll_reset_o,
  output logic       adpll_enable_o,
  output logic [1:0] ref_sel_o,
  output logic       locked_o,
  output logic       fail_o,
  output logic [2:0] state_o,
  output logic [1:0] retry_cnt_o
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int PW = $clog2(ACQ_TIMEOUT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_ACQ  = 3'd2,
    ST_LOCK = 3'd3,
    ST_FAIL = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [PW-1:0] period_q, period_d, period_inc;
  logic [BW-1:0] bad_q, bad_d, bad_inc;
  logic [1:0]    retry_q, retry_d;
  logic [1:0]    sel_q, sel_d;
  logic          reset_q, enable_q, locked_q, fail_q;
  logic          ref_meta_q, ref_sync_q, ref_dly_q;
  logic          smp;
  logic [7:0]    mag;
  logic          good_smp, bad_smp;

  // ref_dly_q only feeds the edge detector; the first two flops are the synchronizer proper.
  always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
    if (!rst_pbn_i) begin
      ref_meta_q <= 1'b0;
      ref_sync_q <= 1'b0;
      ref_dly_q  <= 1'b0;
    end else begin
      ref_meta_q <= ref_clk_i;
      ref_sync_q <= ref_meta_q;
      ref_dly_q  <= ref_sync_q;
    end
  end

  assign smp = ref_sync_q & ~ref_dly_q;

  always_comb begin
    mag = error_i;
    if (error_i == 8'h80)  mag = 8'h7f;
    else if (error_i[7])   mag = ~error_i + 8'd1;
  end

  assign good_smp   = (mag <= 8'(LOCK_TOL));
  assign bad_smp    = (mag > 8'(UNLOCK_TOL));
  assign good_inc   = (good_q == GW'(LOCK_COUNT))    ? good_q   : good_q + 1'b1;
  assign period_inc = (period_q == PW'(ACQ_TIMEOUT)) ? period_q : period_q + 1'b1;
  assign bad_inc    = (bad_q == BW'(UNLOCK_COUNT))   ? bad_q    : bad_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    good_d    = good_q;
    period_d  = period_q;
    bad_d     = bad_q;
    retry_d   = retry_q;
    sel_d     = sel_q;
    if (!start_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sel_d     = ref_sel_req_i;
          retry_d   = 2'd0;
          rst_cnt_d = '0;
          state_d   = ST_HOLD;
        end
        ST_FAIL: state_d = ST_FAIL;
        default: begin
          if (ref_sel_req_i != sel_q) begin
            sel_d     = ref_sel_req_i;
            retry_d   = 2'd0;
            rst_cnt_d = '0;
            state_d   = ST_HOLD;
          end else begin
            case (state_q)
              ST_HOLD: begin
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                  state_d  = ST_ACQ;
                  good_d   = '0;
                  period_d = '0;
                end else begin
                  rst_cnt_d = rst_cnt_q + 1'b1;
                end
              end
              ST_ACQ: begin
                if (smp) begin
                  good_d   = good_smp ? good_inc : '0;
                  period_d = period_inc;
                  // Lock wins over a timeout landing on the same sample.
                  if (good_d == GW'(LOCK_COUNT)) begin
                    state_d = ST_LOCK;
                    bad_d   = '0;
                  end else if (period_d == PW'(ACQ_TIMEOUT)) begin
                    if (retry_q == 2'(MAX_RETRY)) begin
                      state_d = ST_FAIL;
                    end else begin
                      retry_d   = retry_q + 2'd1;
                      rst_cnt_d = '0;
                      state_d   = ST_HOLD;
                    end
                  end
                end
              end
              ST_LOCK: begin
                if (smp) begin
                  bad_d = bad_smp ? bad_inc : '0;
                  if (bad_d == BW'(UNLOCK_COUNT)) begin
                    state_d  = ST_ACQ;
                    good_d   = '0;
                    period_d = '0;
                    bad_d    = '0;
                  end
                end
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
    if (!rst_pbn_i) begin
      state_q   <= ST_IDLE;
      rst_cnt_q <= '0;
      good_q    <= '0;
      period_q  <= '0;
      bad_q     <= '0;
      retry_q   <= 2'd0;
      sel_q     <= 2'd0;
      reset_q   <= 1'b1;
      enable_q  <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      good_q    <= good_d;
      period_q  <= period_d;
      bad_q     <= bad_d;
      retry_q   <= retry_d;
      sel_q     <= sel_d;
      reset_q   <= (state_d == ST_IDLE) || (state_d == ST_HOLD) || (state_d == ST_FAIL);
      enable_q  <= (state_d == ST_ACQ) || (state_d == ST_LOCK);
      locked_q  <= (state_d == ST_LOCK);
      fail_q    <= (state_d == ST_FAIL);
    end
  end

  assign adpll_reset_o  = reset_q;
  assign adpll_enable_o = enable_q;
  assign ref_sel_o      = sel_q;
  assign locked_o       = locked_q;
  assign fail_o         = fail_q;
  assign state_o        = state_q;
  assign retry_cnt_o    = retry_q;

endmodule

// File: tb/tb_adpll_lock_sequencer.sv
// Directed bench for adpll_lock_sequencer: expected output vectors are queued as stimulus is
// driven and popped by a monitor whenever the registered outputs change.
module tb_adpll_lock_sequencer;

  logic       fpga_clk_i = 1'b0;
  logic       rst_pbn_i = 1'b1;
  logic       ref_clk_i = 1'b0;
  logic [7:0] error_i = 8'd0;
  logic       start_i = 1'b0;
  logic [1:0] ref_sel_req_i = 2'd0;
  logic       adpll_reset_o, adpll_enable_o, locked_o, fail_o;
  logic [1:0] ref_sel_o, retry_cnt_o;
  logic [2:0] state_o;

  adpll_lock_sequencer dut (
    .fpga_clk_i     (fpga_clk_i),
    .rst_pbn_i      (rst_pbn_i),
    .ref_clk_i      (ref_clk_i),
    .error_i        (error_i),
    .start_i        (start_i),
    .ref_sel_req_i  (ref_sel_req_i),
    .adpll_reset_o  (adpll_reset_o),
    .adpll_enable_o (adpll_enable_o),
    .ref_sel_o      (ref_sel_o),
    .locked_o       (locked_o),
    .fail_o         (fail_o),
    .state_o        (state_o),
    .retry_cnt_o    (retry_cnt_o)
  );

  always #5 fpga_clk_i = ~fpga_clk_i;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] prev_v;
  bit          mon_en = 1'b0;
  wire  [11:0] out_v = {state_o, adpll_reset_o, adpll_enable_o, locked_o, fail_o, ref_sel_o, retry_cnt_o};

  // Expected output vector for a state, derived from the state's output table.
  function automatic logic [11:0] mk(input logic [2:0] st, input logic [1:0] sel, input logic [1:0] rty);
    logic rst, en, lk, fl;
    rst = (st == 3'd0) || (st == 3'd1) || (st == 3'd4);
    en  = (st == 3'd2) || (st == 3'd3);
    lk  = (st == 3'd3);
    fl  = (st == 3'd4);
    return {st, rst, en, lk, fl, sel, rty};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge fpga_clk_i) begin
    if (mon_en && (out_v !== prev_v)) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 16'(out_v), 16'(prev_v));
      else                   chk("sb_seq", 16'(out_v), 16'(exp_q.pop_front()));
      prev_v <= out_v;
    end
  end

  // One reference period: rising edge mid-cycle, 3 cycles high, 3 low; the sample is consumed before return.
  task automatic smp_drive(input logic [7:0] e);
    @(negedge fpga_clk_i);
    error_i   = e;
    ref_clk_i = 1'b1;
    repeat (3) @(negedge fpga_clk_i);
    ref_clk_i = 1'b0;
    repeat (2) @(negedge fpga_clk_i);
  endtask

  task automatic run(input logic [7:0] e, input int n);
    for (int i = 0; i < n; i++) smp_drive(e);
  endtask

  task automatic hold_len(input string tag);
    int k;
    k = 0;
    @(negedge fpga_clk_i);
    while (state_o == 3'd1 && k < 100) begin
      k++;
      @(negedge fpga_clk_i);
    end
    chk(tag, 16'(k), 16'd16);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int max);
    int n;
    n = 0;
    while (state_o !== st && n < max) begin
      @(negedge fpga_clk_i);
      n++;
    end
    chk(tag, 16'(state_o), 16'(st));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_pbn_i = 1'b0;
    #1 chk("rst_vec", 16'(out_v), 16'(mk(3'd0, 2'd0, 2'd0)));
    prev_v = mk(3'd0, 2'd0, 2'd0);
    mon_en = 1'b1;
    @(negedge fpga_clk_i);
    rst_pbn_i = 1'b1;
    repeat (3) @(negedge fpga_clk_i);
    chk("idle_parked", 16'(out_v), 16'(mk(3'd0, 2'd0, 2'd0)));

    // Clean lock on select 0
    exp_q.push_back(mk(3'd1, 2'd0, 2'd0));
    exp_q.push_back(mk(3'd2, 2'd0, 2'd0));
    start_i = 1'b1;
    hold_len("hold_len_clean");
    run(8'd0, 63);
    chk("pre_lock", 16'(state_o), 16'd2);
    exp_q.push_back(mk(3'd3, 2'd0, 2'd0));
    smp_drive(8'd0);
    chk("locked_64", 16'(locked_o), 16'd1);
    chk("retry_clean", 16'(retry_cnt_o), 16'd0);

    // Unlock hysteresis
    run(8'd9, 3);
    smp_drive(8'd0);
    chk("hyst_hold", 16'(locked_o), 16'd1);
    run(8'h80, 3);
    chk("pre_unlock", 16'(locked_o), 16'd1);
    exp_q.push_back(mk(3'd2, 2'd0, 2'd0));
    smp_drive(8'h80);
    chk("unlock_state", 16'(state_o), 16'd2);
    chk("unlock_no_rst", 16'(adpll_reset_o), 16'd0);

    // Relock with samples at +/-LOCK_TOL, then |error|=UNLOCK_TOL never counts as bad
    exp_q.push_back(mk(3'd3, 2'd0, 2'd0));
    for (int i = 0; i < 32; i++) begin
      smp_drive(8'd2);
      smp_drive(8'hFE);
    end
    chk("relock_tol", 16'(locked_o), 16'd1);
    run(8'hF8, 5);
    chk("unlock_tol_edge", 16'(locked_o), 16'd1);

    // Select change while locked
    exp_q.push_back(mk(3'd1, 2'd1, 2'd0));
    exp_q.push_back(mk(3'd2, 2'd1, 2'd0));
    ref_sel_req_i = 2'd1;
    hold_len("hold_len_sel");
    chk("sel_applied", 16'(ref_sel_o), 16'd1);
    exp_q.push_back(mk(3'd3, 2'd1, 2'd0));
    run(8'd0, 64);
    chk("relock_sel", 16'(locked_o), 16'd1);

    // start_i drop beats a same-cycle select change
    exp_q.push_back(mk(3'd0, 2'd1, 2'd0));
    start_i       = 1'b0;
    ref_sel_req_i = 2'd2;
    repeat (3) @(negedge fpga_clk_i);
    chk("prio_state", 16'(state_o), 16'd0);
    chk("prio_sel", 16'(ref_sel_o), 16'd1);

    // One timeout, then lock and timeout coincide on the 1024th sample
    ref_sel_req_i = 2'd0;
    exp_q.push_back(mk(3'd1, 2'd0, 2'd0));
    exp_q.push_back(mk(3'd2, 2'd0, 2'd0));
    start_i = 1'b1;
    hold_len("hold_len_restart");
    run(8'd9, 1023);
    chk("pre_timeout", 16'(state_o), 16'd2);
    exp_q.push_back(mk(3'd1, 2'd0, 2'd1));
    exp_q.push_back(mk(3'd2, 2'd0, 2'd1));
    smp_drive(8'd9);
    chk("timeout_retry", 16'(retry_cnt_o), 16'd1);
    wait_state("acq_after_retry", 3'd2, 40);
    run(8'd9, 960);
    run(8'd0, 63);
    chk("bnd_pre", 16'(state_o), 16'd2);
    exp_q.push_back(mk(3'd3, 2'd0, 2'd1));
    smp_drive(8'd0);
    chk("bnd_lock", 16'(state_o), 16'd3);
    chk("bnd_retry", 16'(retry_cnt_o), 16'd1);

    // Select change clears the retry count
    exp_q.push_back(mk(3'd1, 2'd1, 2'd0));
    exp_q.push_back(mk(3'd2, 2'd1, 2'd0));
    ref_sel_req_i = 2'd1;
    hold_len("hold_len_sel2");
    chk("sel_retry_clr", 16'(retry_cnt_o), 16'd0);

    // Retries exhaust into FAILED
    for (int a = 1; a <= 4; a++) begin
      if (a < 4) begin
        exp_q.push_back(mk(3'd1, 2'd1, 2'(a)));
        exp_q.push_back(mk(3'd2, 2'd1, 2'(a)));
      end else begin
        exp_q.push_back(mk(3'd4, 2'd1, 2'd3));
      end
      for (int i = 0; i < 1024; i++) smp_drive((((i / 10) % 2) == 1) ? 8'd3 : 8'd0);
      if (a < 4) begin
        chk($sformatf("retry_%0d", a), 16'(retry_cnt_o), 16'(a));
        wait_state($sformatf("acq_retry_%0d", a), 3'd2, 40);
      end else begin
        chk("fail_flag", 16'(fail_o), 16'd1);
        chk("fail_rst", 16'(adpll_reset_o), 16'd1);
      end
    end
    repeat (20) @(negedge fpga_clk_i);
    chk("fail_held", 16'(state_o), 16'd4);
    exp_q.push_back(mk(3'd0, 2'd1, 2'd3));
    start_i = 1'b0;
    repeat (3) @(negedge fpga_clk_i);
    chk("fail_to_idle", 16'(fail_o), 16'd0);

    // Asynchronous reset while locked
    exp_q.push_back(mk(3'd1, 2'd1, 2'd0));
    exp_q.push_back(mk(3'd2, 2'd1, 2'd0));
    start_i = 1'b1;
    hold_len("hold_len_pre_arst");
    exp_q.push_back(mk(3'd3, 2'd1, 2'd0));
    run(8'd0, 64);
    chk("lock_pre_arst", 16'(locked_o), 16'd1);
    @(posedge fpga_clk_i);
    #1;
    exp_q.push_back(mk(3'd0, 2'd0, 2'd0));
    rst_pbn_i = 1'b0;
    start_i   = 1'b0;
    #1 chk("arst_async", 16'(out_v), 16'(mk(3'd0, 2'd0, 2'd0)));
    repeat (2) @(negedge fpga_clk_i);
    rst_pbn_i = 1'b1;
    repeat (3) @(negedge fpga_clk_i);
    chk("post_arst", 16'(out_v), 16'(mk(3'd0, 2'd0, 2'd0)));

    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adpll_lock_sequencer.md
# adpll_lock_sequencer

Controller that sequences the ADPLL through reset, acquisition and lock supervision. It runs on the fast FPGA clock and samples the ADPLL signed phase error once per reference period. It drives the ADPLL's reset and enable and the reference-phase select, retries failed acquisitions, and reports locked/failed status to the top level for LEDs and display.

## Interface
Parameters:
- RST_CYCLES, 16: fpga_clk_i cycles that ADPLL reset is held per attempt (≥2).
- LOCK_TOL, 2: |error| ≤ LOCK_TOL counts as a good sample.
- UNLOCK_TOL, 8: |error| > UNLOCK_TOL counts as a bad sample.
- LOCK_COUNT, 64: consecutive good samples needed to declare lock.
- UNLOCK_COUNT, 4: consecutive bad samples needed to drop lock.
- ACQ_TIMEOUT, 1024: reference periods allowed per acquisition attempt.
- MAX_RETRY, 3: retries after the first attempt before FAILED.

Ports:
- fpga_clk_i  in  1  system clock (258 MHz domain).
- rst_pbn_i  in  1  asynchronous reset, active low.
- ref_clk_i  in  1  reference clock (5 MHz), asynchronous to fpga_clk_i.
- error_i  in  8  signed ADPLL phase error, two's complement.
- start_i  in  1  level; 1 runs the sequencer, 0 parks it in IDLE.
- ref_sel_req_i  in  2  requested reference phase select.
- adpll_reset_o  out  1  active-high reset to the ADPLL.
- adpll_enable_o  out  1  ADPLL enable.
- ref_sel_o  out  2  applied reference phase select.
- locked_o  out  1  high in LOCKED.
- fail_o  out  1  high in FAILED.
- state_o  out  3  current state encoding.
- retry_cnt_o  out  2  retries used in the current sequence.

## Operation
- Strobe: ref_clk_i passes through a 2-flop synchronizer, and a rising edge of the synchronized signal produces a 1-cycle `smp` strobe. error_i is sampled on `smp` only.
- Magnitude: abs(error_i), with -128 saturated to 127. Compare unsigned against the tolerances.
- States (state_o): IDLE=0, HOLD_RST=1, ACQUIRE=2, LOCKED=3, FAILED=4.
- Priority each cycle: start_i=0, then ref-select change, then lock/timeout evaluation.
- IDLE: reset=1, enable=0. When start_i=1: latch ref_sel_o ← ref_sel_req_i, clear retry_cnt, go to HOLD_RST.
- HOLD_RST: reset=1, enable=0. Count RST_CYCLES cycles, then go to ACQUIRE with good_cnt and period_cnt cleared.
- ACQUIRE: reset=0, enable=1. On each `smp`:
  - period_cnt+1.
  - Good sample: good_cnt+1. Any other sample: good_cnt=0.
  - good_cnt reaching LOCK_COUNT goes to LOCKED. Lock takes priority if lock and timeout occur on the same sample.
  - Otherwise period_cnt reaching ACQ_TIMEOUT: if retry_cnt=MAX_RETRY go to FAILED, else retry_cnt+1 and go to HOLD_RST.
- LOCKED: reset=0, enable=1, locked_o=1. On each `smp`:
  - Bad sample: bad_cnt+1. Any other sample: bad_cnt=0.
  - bad_cnt reaching UNLOCK_COUNT goes to ACQUIRE with counters cleared. The ADPLL is not reset, and retry_cnt is unchanged.
- FAILED: reset=1, enable=0, fail_o=1. Held until start_i=0, then IDLE.
- start_i=0 in any state: IDLE on the next cycle, with locked_o=0 and fail_o=0.
- ref_sel_req_i ≠ ref_sel_o in HOLD_RST, ACQUIRE or LOCKED: latch the new select, clear retry_cnt, go to HOLD_RST and restart its counter.
- In IDLE and FAILED the select is not tracked. It is latched on the next start.
- Counter widths are sized from the parameters. Counters saturate, never wrap.

## Timing
- All outputs are registered.
- Reset values (asynchronous, while rst_pbn_i=0):
  - adpll_reset_o=1, adpll_enable_o=0.
  - ref_sel_o=0, locked_o=0, fail_o=0.
  - state_o=0, retry_cnt_o=0.
  - Synchronizer flops=0.
- Reset release: the first active edge evaluates IDLE.
- `smp` is asserted 2–3 fpga_clk_i cycles after a ref_clk_i rising edge.
- Outputs reflect a new state on the cycle after the deciding edge.
- Example: start_i high at edge N puts state_o=1 and ref_sel_o latched after edge N.
- HOLD_RST lasts exactly RST_CYCLES cycles with adpll_reset_o=1.
- adpll_reset_o falls and adpll_enable_o rises on the same edge.
- Lock declared on the LOCK_COUNT-th consecutive good `smp`. locked_o=1 after that edge.
- Unlock: locked_o falls after the UNLOCK_COUNT-th consecutive bad `smp`.
- Asynchronous reset mid-operation returns immediately to the reset values, with no completion of the current state.

## Test plan
- Reset: assert rst_pbn_i=0 mid-LOCKED → outputs go to reset values asynchronously, with state_o=0 and adpll_reset_o=1.
- Clean lock: start_i=1, error_i=0, ref 5 MHz → HOLD_RST for 16 cycles, then ACQUIRE. locked_o=1 after the 64th `smp`, retry_cnt_o=0.
- Retry/fail: error_i alternates 0 / +3 every 10 samples → timeout after 1024 periods, retry_cnt_o counts 1, 2, 3. The fourth timeout gives fail_o=1 and adpll_reset_o=1. start_i=0 then gives IDLE.
- Unlock hysteresis:
  - In LOCKED, apply 3 samples of +9, then 0 → stays LOCKED.
  - Apply 4 samples of -128 (saturated to 127) → ACQUIRE, locked_o=0, adpll_reset_o stays 0.
- Select change: in LOCKED, change ref_sel_req_i 0→1 → ref_sel_o=1, HOLD_RST for 16 cycles, retry_cnt_o=0, then relock.
- Priority: in the same cycle, drop start_i and change ref_sel_req_i → IDLE, ref_sel_o unchanged.
- Boundary: good_cnt reaches 64 on the sample where period_cnt reaches 1024 → LOCKED, not a retry.
